pu_riscv_ahb3_arbiter: RTL and testbench

Parametrised N-master AHB3-Lite arbiter that merges the instruction and data AHB3 ports of one or more PU cores onto a single AHB3-Lite master port. Provides round-robin or fixed-priority arbitration, burst and HMASTLOCK retention, and per-port address-phase capture so losing masters are stalled instead of dropped. Sits between the PU AHB3 ports and the system interconnect.

---
 rtl/pu_riscv_ahb3_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_pu_riscv_ahb3_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pu_riscv_ahb3_arbiter.sv
// pu_riscv_ahb3_arbiter
//   Merges MASTERS upstream AHB3-Lite master ports (PU instruction/data
//   ports) onto one downstream AHB3-Lite master port.
//   - Round-robin (RR=1) or fixed lowest-index priority (RR=0).
//   - Owner keeps the bus through SEQ/BUSY beats and while HMASTLOCK is high.
//   - A port that loses arbitration has its address phase captured in a
//     per-port latch and is stalled (m_HREADY low) until that transfer's
//     downstream data phase completes, so no request is ever dropped.
// Ports
//   HCLK, HRESET            clock, asynchronous active-high reset
//   m_H*                    upstream AHB3 ports, one slice per master
//   m_HRDATA                read data broadcast to every port
//   m_HREADY / m_HRESP      per-port ready / response
//   s_H*                    downstream AHB3-Lite master port
module pu_riscv_ahb3_arbiter #(
  parameter int MASTERS = 2,
  parameter int XLEN    = 32,
  parameter int PLEN    = 32,
  parameter int RR      = 1
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [MASTERS-1:0]             m_HSEL,
  input  logic [MASTERS-1:0][PLEN-1:0]   m_HADDR,
  input  logic [MASTERS-1:0][XLEN-1:0]   m_HWDATA,
  output logic [XLEN-1:0]                m_HRDATA,
  input  logic [MASTERS-1:0]             m_HWRITE,
  input  logic [MASTERS-1:0][2:0]        m_HSIZE,
  input  logic [MASTERS-1:0][2:0]        m_HBURST,
  input  logic [MASTERS-1:0][3:0]        m_HPROT,
  input  logic [MASTERS-1:0][1:0]        m_HTRANS,
  input  logic [MASTERS-1:0]             m_HMASTLOCK,
  output logic [MASTERS-1:0]             m_HREADY,
  output logic [MASTERS-1:0]             m_HRESP,
  output logic                           s_HSEL,
  output logic [PLEN-1:0]                s_HADDR,
  output logic [XLEN-1:0]                s_HWDATA,
  input  logic [XLEN-1:0]                s_HRDATA,
  output logic                           s_HWRITE,
  output logic [2:0]                     s_HSIZE,
  output logic [2:0]                     s_HBURST,
  output logic [3:0]                     s_HPROT,
  output logic [1:0]                     s_HTRANS,
  output logic                           s_HMASTLOCK,
  input  logic                           s_HREADY,
  input  logic                           s_HRESP
);

  localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  // registered state
  logic [MASTERS-1:0]           pend_v_reg;
  logic [MASTERS-1:0][PLEN-1:0] pend_addr_reg;
  logic [MASTERS-1:0]           pend_write_reg;
  logic [MASTERS-1:0][2:0]      pend_size_reg;
  logic [MASTERS-1:0][2:0]      pend_burst_reg;
  logic [MASTERS-1:0][3:0]      pend_prot_reg;
  logic [MASTERS-1:0][1:0]      pend_trans_reg;
  logic [MASTERS-1:0]           pend_lock_reg;
  logic [IW-1:0]                owner_reg;
  logic                         dp_v_reg;
  logic [IW-1:0]                dp_id_reg;

  // effective per-port address phase: latched copy if pending, else live
  logic [MASTERS-1:0]           live_req;
  logic [MASTERS-1:0]           req;
  logic [MASTERS-1:0]           eff_sel;
  logic [MASTERS-1:0][PLEN-1:0] eff_addr;
  logic [MASTERS-1:0]           eff_write;
  logic [MASTERS-1:0][2:0]      eff_size;
  logic [MASTERS-1:0][2:0]      eff_burst;
  logic [MASTERS-1:0][3:0]      eff_prot;
  logic [MASTERS-1:0][1:0]      eff_trans;
  logic [MASTERS-1:0]           eff_lock;

  logic [IW-1:0] grant;
  logic          keep;
  logic          drive;

  genvar gi;
  generate
    for (gi = 0; gi < MASTERS; gi++) begin : g_port
      // HTRANS[1] set means NONSEQ or SEQ
      assign live_req[gi]  = m_HSEL[gi] & m_HTRANS[gi][1];
      assign req[gi]       = live_req[gi] | pend_v_reg[gi];
      assign eff_sel[gi]   = pend_v_reg[gi] | m_HSEL[gi];
      assign eff_addr[gi]  = pend_v_reg[gi] ? pend_addr_reg[gi]  : m_HADDR[gi];
      assign eff_write[gi] = pend_v_reg[gi] ? pend_write_reg[gi] : m_HWRITE[gi];
      assign eff_size[gi]  = pend_v_reg[gi] ? pend_size_reg[gi]  : m_HSIZE[gi];
      assign eff_burst[gi] = pend_v_reg[gi] ? pend_burst_reg[gi] : m_HBURST[gi];
      assign eff_prot[gi]  = pend_v_reg[gi] ? pend_prot_reg[gi]  : m_HPROT[gi];
      assign eff_trans[gi] = pend_v_reg[gi] ? pend_trans_reg[gi] : m_HTRANS[gi];
      assign eff_lock[gi]  = pend_v_reg[gi] ? pend_lock_reg[gi]  : m_HMASTLOCK[gi];

      // Port in the data phase sees the slave's ready; a port with a
      // captured-but-not-issued transfer is stalled; everyone else is free.
      assign m_HREADY[gi] = (dp_v_reg && dp_id_reg == IW'(gi)) ? s_HREADY :
                            !pend_v_reg[gi];
      assign m_HRESP[gi]  = dp_v_reg && dp_id_reg == IW'(gi) && s_HRESP;

      // Capture also covers the corner where this port is granted but the
      // downstream slot is stalled: the master already saw HREADY high, so
      // the transfer must be kept until it is really accepted.
      always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
          pend_v_reg[gi]     <= 1'b0;
          pend_addr_reg[gi]  <= '0;
          pend_write_reg[gi] <= 1'b0;
          pend_size_reg[gi]  <= '0;
          pend_burst_reg[gi] <= '0;
          pend_prot_reg[gi]  <= '0;
          pend_trans_reg[gi] <= HTRANS_IDLE;
          pend_lock_reg[gi]  <= 1'b0;
        end else if (pend_v_reg[gi] && grant == IW'(gi) && s_HREADY) begin
          pend_v_reg[gi] <= 1'b0;
        end else if (m_HREADY[gi] && live_req[gi] &&
                     !(grant == IW'(gi) && s_HREADY)) begin
          pend_v_reg[gi]     <= 1'b1;
          pend_addr_reg[gi]  <= m_HADDR[gi];
          pend_write_reg[gi] <= m_HWRITE[gi];
          pend_size_reg[gi]  <= m_HSIZE[gi];
          pend_burst_reg[gi] <= m_HBURST[gi];
          pend_prot_reg[gi]  <= m_HPROT[gi];
          pend_trans_reg[gi] <= m_HTRANS[gi];
          pend_lock_reg[gi]  <= m_HMASTLOCK[gi];
        end
      end
    end
  endgenerate

  // Owner retains the bus mid-burst (SEQ/BUSY) and while locked.
  assign keep = eff_sel[owner_reg] &&
                (eff_trans[owner_reg] == HTRANS_SEQ ||
                 eff_trans[owner_reg] == HTRANS_BUSY ||
                 eff_lock[owner_reg]);

  // Loops run from the lowest-priority candidate upward so the last hit,
  // i.e. the highest-priority requester, wins. No requester parks on owner.
  always_comb begin
    grant = owner_reg;
    if (s_HREADY && !keep) begin
      if (RR != 0) begin
        for (int i = MASTERS; i >= 1; i--) begin
          if (req[(int'(owner_reg) + i) % MASTERS])
            grant = IW'((int'(owner_reg) + i) % MASTERS);
        end
      end else begin
        for (int i = MASTERS - 1; i >= 0; i--) begin
          if (req[i]) grant = IW'(i);
        end
      end
    end
  end

  assign drive = !HRESET && (keep || req[grant]);

  assign s_HSEL      = drive;
  assign s_HADDR     = drive ? eff_addr[grant]  : '0;
  assign s_HWRITE    = drive ? eff_write[grant] : 1'b0;
  assign s_HSIZE     = drive ? eff_size[grant]  : '0;
  assign s_HBURST    = drive ? eff_burst[grant] : '0;
  assign s_HPROT     = drive ? eff_prot[grant]  : '0;
  assign s_HTRANS    = drive ? eff_trans[grant] : HTRANS_IDLE;
  assign s_HMASTLOCK = drive ? eff_lock[grant]  : 1'b0;

  assign s_HWDATA = dp_v_reg ? m_HWDATA[dp_id_reg] : '0;
  assign m_HRDATA = s_HRDATA;

  // Only NONSEQ/SEQ open a data phase; IDLE/BUSY slots do not.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      owner_reg <= '0;
      dp_v_reg  <= 1'b0;
      dp_id_reg <= '0;
    end else if (s_HREADY) begin
      owner_reg <= grant;
      dp_v_reg  <= drive && s_HTRANS[1];
      dp_id_reg <= grant;
    end
  end

endmodule

// File: tb/tb_pu_riscv_ahb3_arbiter.sv
// Directed bench for pu_riscv_ahb3_arbiter: a round-robin instance (u_rr)
// and a fixed-priority instance (u_fp) share the same upstream stimulus.
module tb_pu_riscv_ahb3_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic             HCLK = 1'b0;
  logic             HRESET;
  logic [1:0]       m_HSEL, m_HWRITE, m_HMASTLOCK;
  logic [1:0][31:0] m_HADDR, m_HWDATA;
  logic [1:0][2:0]  m_HSIZE, m_HBURST;
  logic [1:0][3:0]  m_HPROT;
  logic [1:0][1:0]  m_HTRANS;
  logic [31:0]      s_HRDATA;
  logic             s_HREADY, s_HRESP;

  logic [31:0] m_HRDATA, fp_m_HRDATA;
  logic [1:0]  m_HREADY, m_HRESP, fp_m_HREADY, fp_m_HRESP;
  logic        s_HSEL, s_HWRITE, s_HMASTLOCK;
  logic        fp_s_HSEL, fp_s_HWRITE, fp_s_HMASTLOCK;
  logic [31:0] s_HADDR, s_HWDATA, fp_s_HADDR, fp_s_HWDATA;
  logic [2:0]  s_HSIZE, s_HBURST, fp_s_HSIZE, fp_s_HBURST;
  logic [3:0]  s_HPROT, fp_s_HPROT;
  logic [1:0]  s_HTRANS, fp_s_HTRANS;

  int total;
  int bad;

  always #5 HCLK = ~HCLK;

  pu_riscv_ahb3_arbiter #(.MASTERS(2), .XLEN(32), .PLEN(32), .RR(1)) u_rr (
    .HCLK(HCLK), .HRESET(HRESET),
    .m_HSEL(m_HSEL), .m_HADDR(m_HADDR), .m_HWDATA(m_HWDATA), .m_HRDATA(m_HRDATA),
    .m_HWRITE(m_HWRITE), .m_HSIZE(m_HSIZE), .m_HBURST(m_HBURST), .m_HPROT(m_HPROT),
    .m_HTRANS(m_HTRANS), .m_HMASTLOCK(m_HMASTLOCK), .m_HREADY(m_HREADY), .m_HRESP(m_HRESP),
    .s_HSEL(s_HSEL), .s_HADDR(s_HADDR), .s_HWDATA(s_HWDATA), .s_HRDATA(s_HRDATA),
    .s_HWRITE(s_HWRITE), .s_HSIZE(s_HSIZE), .s_HBURST(s_HBURST), .s_HPROT(s_HPROT),
    .s_HTRANS(s_HTRANS), .s_HMASTLOCK(s_HMASTLOCK), .s_HREADY(s_HREADY), .s_HRESP(s_HRESP)
  );

  pu_riscv_ahb3_arbiter #(.MASTERS(2), .XLEN(32), .PLEN(32), .RR(0)) u_fp (
    .HCLK(HCLK), .HRESET(HRESET),
    .m_HSEL(m_HSEL), .m_HADDR(m_HADDR), .m_HWDATA(m_HWDATA), .m_HRDATA(fp_m_HRDATA),
    .m_HWRITE(m_HWRITE), .m_HSIZE(m_HSIZE), .m_HBURST(m_HBURST), .m_HPROT(m_HPROT),
    .m_HTRANS(m_HTRANS), .m_HMASTLOCK(m_HMASTLOCK), .m_HREADY(fp_m_HREADY), .m_HRESP(fp_m_HRESP),
    .s_HSEL(fp_s_HSEL), .s_HADDR(fp_s_HADDR), .s_HWDATA(fp_s_HWDATA), .s_HRDATA(s_HRDATA),
    .s_HWRITE(fp_s_HWRITE), .s_HSIZE(fp_s_HSIZE), .s_HBURST(fp_s_HBURST), .s_HPROT(fp_s_HPROT),
    .s_HTRANS(fp_s_HTRANS), .s_HMASTLOCK(fp_s_HMASTLOCK), .s_HREADY(s_HREADY), .s_HRESP(s_HRESP)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("  ok %s = %0h", tag, obs);
    end
  endtask

  task automatic idle_all();
    m_HSEL = '0; m_HWRITE = '0; m_HMASTLOCK = '0;
    m_HADDR = '0; m_HSIZE = '0; m_HBURST = '0; m_HPROT = '0; m_HTRANS = '0;
  endtask

  task automatic drop(input int p);
    m_HSEL[p] = 1'b0; m_HTRANS[p] = IDLE; m_HMASTLOCK[p] = 1'b0;
    m_HADDR[p] = '0; m_HWRITE[p] = 1'b0; m_HBURST[p] = '0;
  endtask

  task automatic req(input int p, input logic [1:0] tr, input logic [31:0] a,
                     input logic w, input logic lk, input logic [2:0] bu);
    m_HSEL[p] = 1'b1; m_HTRANS[p] = tr; m_HADDR[p] = a; m_HWRITE[p] = w;
    m_HMASTLOCK[p] = lk; m_HBURST[p] = bu; m_HSIZE[p] = 3'd2; m_HPROT[p] = 4'h3;
  endtask

  task automatic nxt();
    @(posedge HCLK);
    #1;
  endtask

  task automatic mid();
    @(negedge HCLK);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    HRESET = 1'b1;
    idle_all();
    m_HWDATA = '0;
    s_HREADY = 1'b1; s_HRESP = 1'b0; s_HRDATA = '0;

    // reset state
    mid();
    check("rst_trans",  s_HTRANS, IDLE);
    check("rst_sel",    s_HSEL, 1'b0);
    check("rst_hready", m_HREADY, 2'b11);
    check("rst_hresp",  m_HRESP, 2'b00);
    check("rst_addr",   s_HADDR, 32'h0);

    // single uncontended read
    nxt(); HRESET = 1'b0;
    req(0, NONSEQ, 32'h8000_0000, 1'b0, 1'b0, 3'd0);
    mid();
    check("rd_addr",  s_HADDR, 32'h8000_0000);
    check("rd_trans", s_HTRANS, NONSEQ);
    check("rd_sel",   s_HSEL, 1'b1);
    nxt(); idle_all(); s_HRDATA = 32'hDEAD_BEEF;
    mid();
    check("rd_data",   m_HRDATA, 32'hDEAD_BEEF);
    check("rd_ready0", m_HREADY[0], 1'b1);

    // simultaneous NONSEQ from both ports
    nxt(); idle_all(); s_HRDATA = '0;
    req(0, NONSEQ, 32'h0000_0100, 1'b0, 1'b0, 3'd0);
    req(1, NONSEQ, 32'h0000_0200, 1'b0, 1'b0, 3'd0);
    mid();
    check("rr_first",   s_HADDR, 32'h0000_0200);
    check("fp_first",   fp_s_HADDR, 32'h0000_0100);
    check("both_ready", m_HREADY, 2'b11);
    nxt(); idle_all();
    mid();
    check("rr_second",       s_HADDR, 32'h0000_0100);
    check("rr_second_trans", s_HTRANS, NONSEQ);
    check("rr_stall0",       m_HREADY, 2'b10);
    check("fp_second",       fp_s_HADDR, 32'h0000_0200);
    check("fp_stall1",       fp_m_HREADY, 2'b01);
    nxt();
    mid();
    check("rr_release0", m_HREADY, 2'b11);
    check("rr_idle",     s_HTRANS, IDLE);

    // INCR4 burst on port 0, port 1 arrives at beat 2
    nxt(); req(0, NONSEQ, 32'h0000_1000, 1'b0, 1'b0, 3'd3);
    mid();
    check("b1_addr",  s_HADDR, 32'h0000_1000);
    check("b1_burst", s_HBURST, 3'd3);
    nxt(); req(0, SEQ, 32'h0000_1004, 1'b0, 1'b0, 3'd3);
    req(1, NONSEQ, 32'h0000_2000, 1'b0, 1'b0, 3'd0);
    mid();
    check("b2_addr",   s_HADDR, 32'h0000_1004);
    check("b2_ready1", m_HREADY[1], 1'b1);
    nxt(); drop(1); req(0, SEQ, 32'h0000_1008, 1'b0, 1'b0, 3'd3);
    mid();
    check("b3_addr",  s_HADDR, 32'h0000_1008);
    check("b3_stall1", m_HREADY[1], 1'b0);
    nxt(); req(0, SEQ, 32'h0000_100C, 1'b0, 1'b0, 3'd3);
    mid();
    check("b4_addr", s_HADDR, 32'h0000_100C);
    nxt(); idle_all();
    mid();
    check("b5_addr",  s_HADDR, 32'h0000_2000);
    check("b5_trans", s_HTRANS, NONSEQ);
    nxt();
    mid();
    check("b_release1", m_HREADY, 2'b11);

    // locked pair from port 1 while port 0 waits
    nxt(); req(1, NONSEQ, 32'h0000_3000, 1'b0, 1'b1, 3'd0);
    req(0, NONSEQ, 32'h0000_4000, 1'b0, 1'b0, 3'd0);
    mid();
    check("l1_addr", s_HADDR, 32'h0000_3000);
    check("l1_lock", s_HMASTLOCK, 1'b1);
    nxt(); drop(0); req(1, NONSEQ, 32'h0000_3004, 1'b0, 1'b1, 3'd0);
    mid();
    check("l2_addr",   s_HADDR, 32'h0000_3004);
    check("l2_lock",   s_HMASTLOCK, 1'b1);
    check("l2_stall0", m_HREADY[0], 1'b0);
    nxt(); idle_all();
    mid();
    check("l3_addr", s_HADDR, 32'h0000_4000);
    check("l3_lock", s_HMASTLOCK, 1'b0);
    nxt();
    mid();
    check("l_release0", m_HREADY[0], 1'b1);

    // write with two-cycle ERROR response
    nxt(); req(0, NONSEQ, 32'h0000_5000, 1'b1, 1'b0, 3'd0);
    mid();
    check("e_write", s_HWRITE, 1'b1);
    nxt(); idle_all();
    m_HWDATA[0] = 32'hCAFE_F00D; m_HWDATA[1] = 32'h1111_1111;
    s_HREADY = 1'b0; s_HRESP = 1'b1;
    mid();
    check("e_wdata",   s_HWDATA, 32'hCAFE_F00D);
    check("e1_resp",   m_HRESP, 2'b01);
    check("e1_ready0", m_HREADY[0], 1'b0);
    nxt(); s_HREADY = 1'b1;
    mid();
    check("e2_resp",   m_HRESP, 2'b01);
    check("e2_ready0", m_HREADY[0], 1'b1);
    nxt(); s_HRESP = 1'b0; m_HWDATA = '0;
    mid();
    check("e_clear", m_HRESP, 2'b00);

    // reset mid-burst with port 1 captured
    nxt(); req(0, NONSEQ, 32'h0000_6000, 1'b0, 1'b0, 3'd3);
    mid();
    check("r1_addr", s_HADDR, 32'h0000_6000);
    nxt(); req(0, SEQ, 32'h0000_6004, 1'b0, 1'b0, 3'd3);
    req(1, NONSEQ, 32'h0000_7000, 1'b0, 1'b0, 3'd0);
    mid();
    check("r2_addr", s_HADDR, 32'h0000_6004);
    nxt();
    check("r3_pend1", m_HREADY[1], 1'b0);
    drop(1); req(0, SEQ, 32'h0000_6008, 1'b0, 1'b0, 3'd3);
    HRESET = 1'b1;
    mid();
    check("r3_trans",  s_HTRANS, IDLE);
    check("r3_sel",    s_HSEL, 1'b0);
    check("r3_hready", m_HREADY, 2'b11);
    check("r3_lock",   s_HMASTLOCK, 1'b0);
    check("r3_addr",   s_HADDR, 32'h0);
    nxt(); HRESET = 1'b0; idle_all();
    req(1, NONSEQ, 32'h0000_7100, 1'b0, 1'b0, 3'd0);
    mid();
    check("post_addr",   s_HADDR, 32'h0000_7100);
    check("post_trans",  s_HTRANS, NONSEQ);
    check("post_ready0", m_HREADY[0], 1'b1);
    nxt(); idle_all();
    mid();
    check("post_done", m_HREADY, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
